// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for a 5-stage RISC-V pipeline
//
// Purpose: after a boot hold following reset, decides every cycle which
// pipeline registers load, hold or take a NOP. The decision is a fixed
// priority: data-memory stall > taken-branch redirect > load-use bubble >
// instruction-memory stall > run. Also keeps saturating stall/bubble
// statistics and a sticky data-memory watchdog flag.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-low reset
//   IMEM_BUSYWAIT, DMEM_BUSYWAIT  memory not-ready inputs
//   EX_BRANCH_TAKEN            taken branch/jump resolved in EX
//   EX_MEM_READ, EX_RD         load in EX and its destination register
//   ID_RS1/2, ID_USES_RS1/2    source registers of the instruction in ID
//   CNT_CLEAR                  synchronous clear of the statistics counters
//   *_ENABLE                   per-stage load enables (PC .. MEM_WB)
//   IF_ID_FLUSH, ID_EX_FLUSH   NOP insertion, override the matching enable
//   CTRL_STATE                 previous cycle's decision class
//   STALL_CYCLES, BUBBLE_COUNT saturating statistics
//   MEM_TIMEOUT                sticky watchdog flag
module pipeline_hazard_controller #(
  parameter int BOOT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IMEM_BUSYWAIT,
  input  logic                 DMEM_BUSYWAIT,
  input  logic                 EX_BRANCH_TAKEN,
  input  logic                 EX_MEM_READ,
  input  logic [4:0]           EX_RD,
  input  logic [4:0]           ID_RS1,
  input  logic [4:0]           ID_RS2,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic                 CNT_CLEAR,
  output logic                 PC_ENABLE,
  output logic                 IF_ID_ENABLE,
  output logic                 ID_EX_ENABLE,
  output logic                 EX_MEM_ENABLE,
  output logic                 MEM_WB_ENABLE,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_FLUSH,
  output logic [2:0]           CTRL_STATE,
  output logic [CNT_WIDTH-1:0] STALL_CYCLES,
  output logic [CNT_WIDTH-1:0] BUBBLE_COUNT,
  output logic                 MEM_TIMEOUT
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    CLS_BOOT     = 3'd0,
    CLS_RUN      = 3'd1,
    CLS_DSTALL   = 3'd2,
    CLS_REDIRECT = 3'd3,
    CLS_BUBBLE   = 3'd4,
    CLS_ISTALL   = 3'd5
  } cls_e;

  typedef enum logic {
    PH_BOOT = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
  cls_e            cls_d;
  logic [2:0]      ctrl_state_q;
  logic [CNT_WIDTH-1:0] stall_q, bubble_q;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            timeout_q;
  logic            load_use;

  // Phase register: BOOT counts edges after reset release, then RUN forever.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_q    <= PH_BOOT;
      boot_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    boot_cnt_d = boot_cnt_q;
    if (phase_q == PH_BOOT) begin
      if (boot_cnt_q == BOOT_LAST) begin
        phase_d = PH_RUN;
      end else begin
        boot_cnt_d = boot_cnt_q + 1'b1;
      end
    end
  end

  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  // Decision class for this cycle; fixed priority, combinational from inputs.
  always_comb begin
    cls_d = CLS_RUN;
    if (phase_q == PH_BOOT)  cls_d = CLS_BOOT;
    else if (DMEM_BUSYWAIT)  cls_d = CLS_DSTALL;
    else if (EX_BRANCH_TAKEN) cls_d = CLS_REDIRECT;
    else if (load_use)       cls_d = CLS_BUBBLE;
    else if (IMEM_BUSYWAIT)  cls_d = CLS_ISTALL;
  end

  // Output decode. A bubble keeps IF_ID and PC so the dependent instruction
  // retries, while ID_EX loads a NOP; an IMEM stall instead lets the
  // pipeline drain behind a NOP in IF_ID.
  always_comb begin
    PC_ENABLE     = 1'b1;
    IF_ID_ENABLE  = 1'b1;
    ID_EX_ENABLE  = 1'b1;
    EX_MEM_ENABLE = 1'b1;
    MEM_WB_ENABLE = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    case (cls_d)
      CLS_BOOT, CLS_DSTALL: begin
        PC_ENABLE     = 1'b0;
        IF_ID_ENABLE  = 1'b0;
        ID_EX_ENABLE  = 1'b0;
        EX_MEM_ENABLE = 1'b0;
        MEM_WB_ENABLE = 1'b0;
        IF_ID_FLUSH   = (cls_d == CLS_BOOT);
        ID_EX_FLUSH   = (cls_d == CLS_BOOT);
      end
      CLS_REDIRECT: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end
      CLS_BUBBLE: begin
        PC_ENABLE    = 1'b0;
        IF_ID_ENABLE = 1'b0;
        ID_EX_FLUSH  = 1'b1;
      end
      CLS_ISTALL: begin
        PC_ENABLE   = 1'b0;
        IF_ID_FLUSH = 1'b1;
      end
      default: ;
    endcase
  end

  // Watchdog counter saturates at the limit so it never wraps back to zero
  // while the stall persists.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (phase_q == PH_RUN) begin
      if (!DMEM_BUSYWAIT)          wd_cnt_d = '0;
      else if (wd_cnt_q != WD_LIMIT) wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_state_q <= CLS_BOOT;
      stall_q      <= '0;
      bubble_q     <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      ctrl_state_q <= cls_d;
      wd_cnt_q     <= wd_cnt_d;
      if (wd_cnt_d == WD_LIMIT) timeout_q <= 1'b1;
      if (CNT_CLEAR) begin
        stall_q  <= '0;
        bubble_q <= '0;
      end else begin
        if ((cls_d == CLS_DSTALL || cls_d == CLS_ISTALL) && (stall_q != '1))
          stall_q <= stall_q + 1'b1;
        if ((cls_d == CLS_BUBBLE) && (bubble_q != '1))
          bubble_q <= bubble_q + 1'b1;
      end
    end
  end

  assign CTRL_STATE   = ctrl_state_q;
  assign STALL_CYCLES = stall_q;
  assign BUBBLE_COUNT = bubble_q;
  assign MEM_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed vector bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IMEM_BUSYWAIT, DMEM_BUSYWAIT, EX_BRANCH_TAKEN, EX_MEM_READ;
  logic [4:0] EX_RD, ID_RS1, ID_RS2;
  logic       ID_USES_RS1, ID_USES_RS2, CNT_CLEAR;
  logic       PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE;
  logic       IF_ID_FLUSH, ID_EX_FLUSH;
  logic [2:0] CTRL_STATE;
  logic [3:0] STALL_CYCLES, BUBBLE_COUNT;
  logic       MEM_TIMEOUT;

  pipeline_hazard_controller #(
    .BOOT_CYCLES(2), .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_MEM_READ(EX_MEM_READ),
    .EX_RD(EX_RD), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .CNT_CLEAR(CNT_CLEAR),
    .PC_ENABLE(PC_ENABLE), .IF_ID_ENABLE(IF_ID_ENABLE), .ID_EX_ENABLE(ID_EX_ENABLE),
    .EX_MEM_ENABLE(EX_MEM_ENABLE), .MEM_WB_ENABLE(MEM_WB_ENABLE),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .CTRL_STATE(CTRL_STATE), .STALL_CYCLES(STALL_CYCLES),
    .BUBBLE_COUNT(BUBBLE_COUNT), .MEM_TIMEOUT(MEM_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Output vector order: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID_FLUSH, ID_EX_FLUSH}
  localparam logic [6:0] O_RUN  = 7'b1111100;
  localparam logic [6:0] O_BUB  = 7'b0011101;
  localparam logic [6:0] O_IST  = 7'b0111110;
  localparam logic [6:0] O_RED  = 7'b1111111;
  localparam logic [6:0] O_DST  = 7'b0000000;
  localparam logic [6:0] O_BOOT = 7'b0000011;

  typedef struct {
    logic       imem, dmem, br, mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [6:0] exp_o;
    logic [2:0] exp_st;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tv[13];
  int exp_stall, exp_bub;

  function automatic vec_t mk(input logic imem, input logic dmem, input logic br,
                              input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic [6:0] eo, input logic [2:0] es);
    vec_t v;
    v.imem = imem; v.dmem = dmem; v.br = br; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exp_o = eo; v.exp_st = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {PC_ENABLE, IF_ID_ENABLE, ID_EX_ENABLE, EX_MEM_ENABLE, MEM_WB_ENABLE,
            IF_ID_FLUSH, ID_EX_FLUSH};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0; EX_BRANCH_TAKEN = 0; EX_MEM_READ = 0;
    EX_RD = 0; ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    CNT_CLEAR = 0;
  endtask

  initial begin
    RESET = 1'b0;
    idle();

    // Reset and boot hold
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("reset_outs", 32'(outs()), 32'(O_BOOT));
      tick();
    end
    chk("reset_state", 32'(CTRL_STATE), 32'd0);
    chk("reset_stall", 32'(STALL_CYCLES), 32'd0);
    chk("reset_bubble", 32'(BUBBLE_COUNT), 32'd0);
    chk("reset_timeout", 32'(MEM_TIMEOUT), 32'd0);
    RESET = 1'b1;
    #4 chk("boot_pre_edge1", 32'(outs()), 32'(O_BOOT));
    tick();
    #4 chk("boot_after_edge1", 32'(outs()), 32'(O_BOOT));
    tick();
    chk("boot_state_edge2", 32'(CTRL_STATE), 32'd0);
    #4 chk("run_after_boot", 32'(outs()), 32'(O_RUN));
    tick();
    chk("run_state_lag", 32'(CTRL_STATE), 32'd1);

    // Single-cycle decision vectors
    tv[0]  = mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 3'd1);
    tv[1]  = mk(0,0,0,1, 5'd5, 5'd0, 5'd5, 0,1, O_BUB, 3'd4);
    tv[2]  = mk(0,0,0,1, 5'd0, 5'd0, 5'd0, 1,1, O_RUN, 3'd1);
    tv[3]  = mk(0,0,0,1, 5'd7, 5'd7, 5'd3, 1,0, O_BUB, 3'd4);
    tv[4]  = mk(0,0,0,1, 5'd7, 5'd7, 5'd3, 0,1, O_RUN, 3'd1);
    tv[5]  = mk(0,0,0,0, 5'd5, 5'd5, 5'd5, 1,1, O_RUN, 3'd1);
    tv[6]  = mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_IST, 3'd5);
    tv[7]  = mk(1,0,0,1, 5'd9, 5'd9, 5'd0, 1,0, O_BUB, 3'd4);
    tv[8]  = mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_RED, 3'd3);
    tv[9]  = mk(1,0,1,1, 5'd4, 5'd4, 5'd4, 1,1, O_RED, 3'd3);
    tv[10] = mk(0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_DST, 3'd2);
    tv[11] = mk(1,1,1,1, 5'd6, 5'd6, 5'd6, 1,1, O_DST, 3'd2);
    tv[12] = mk(0,0,0,1, 5'd8, 5'd2, 5'd8, 1,0, O_RUN, 3'd1);

    CNT_CLEAR = 1;
    tick();
    CNT_CLEAR = 0;
    exp_stall = 0;
    exp_bub   = 0;
    for (int i = 0; i < 13; i++) begin
      IMEM_BUSYWAIT = tv[i].imem; DMEM_BUSYWAIT = tv[i].dmem;
      EX_BRANCH_TAKEN = tv[i].br; EX_MEM_READ = tv[i].mr;
      EX_RD = tv[i].rd; ID_RS1 = tv[i].rs1; ID_RS2 = tv[i].rs2;
      ID_USES_RS1 = tv[i].u1; ID_USES_RS2 = tv[i].u2;
      #4 chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tv[i].exp_o));
      tick();
      chk($sformatf("vec%0d_state", i), 32'(CTRL_STATE), 32'(tv[i].exp_st));
      if (tv[i].exp_st == 3'd2 || tv[i].exp_st == 3'd5) exp_stall++;
      if (tv[i].exp_st == 3'd4) exp_bub++;
    end
    idle();
    chk("table_stall_cnt", 32'(STALL_CYCLES), 32'(exp_stall));
    chk("table_bubble_cnt", 32'(BUBBLE_COUNT), 32'(exp_bub));

    // DMEM stall holds a pending branch, which fires after the stall clears
    CNT_CLEAR = 1;
    tick();
    CNT_CLEAR = 0;
    chk("clear_stall", 32'(STALL_CYCLES), 32'd0);
    DMEM_BUSYWAIT = 1; EX_BRANCH_TAKEN = 1;
    for (int i = 0; i < 4; i++) begin
      #4 chk($sformatf("dstall_br_c%0d", i), 32'(outs()), 32'(O_DST));
      tick();
    end
    DMEM_BUSYWAIT = 0;
    #4 chk("redirect_after_dstall", 32'(outs()), 32'(O_RED));
    tick();
    chk("redirect_state", 32'(CTRL_STATE), 32'd3);
    chk("dstall_count4", 32'(STALL_CYCLES), 32'd4);
    idle();

    // Load-use during a DMEM stall counts only once the stall clears
    DMEM_BUSYWAIT = 1; EX_MEM_READ = 1; EX_RD = 5'd11; ID_RS1 = 5'd11; ID_USES_RS1 = 1;
    tick();
    tick();
    chk("bubble_held_in_dstall", 32'(BUBBLE_COUNT), 32'd0);
    DMEM_BUSYWAIT = 0;
    #4 chk("bubble_after_dstall", 32'(outs()), 32'(O_BUB));
    tick();
    chk("bubble_count_once", 32'(BUBBLE_COUNT), 32'd1);
    idle();
    tick();

    // Watchdog: 7 high, 1 low, 8 high
    DMEM_BUSYWAIT = 1;
    repeat (7) tick();
    chk("wd_7_cycles", 32'(MEM_TIMEOUT), 32'd0);
    DMEM_BUSYWAIT = 0;
    tick();
    chk("wd_gap", 32'(MEM_TIMEOUT), 32'd0);
    DMEM_BUSYWAIT = 1;
    repeat (7) tick();
    chk("wd_second_7", 32'(MEM_TIMEOUT), 32'd0);
    tick();
    chk("wd_second_8", 32'(MEM_TIMEOUT), 32'd1);
    #4 chk("wd_still_stalls", 32'(outs()), 32'(O_DST));
    DMEM_BUSYWAIT = 0;
    tick();
    chk("wd_sticky", 32'(MEM_TIMEOUT), 32'd1);

    // Saturation and clear-during-stall
    CNT_CLEAR = 1;
    tick();
    CNT_CLEAR = 0;
    IMEM_BUSYWAIT = 1;
    repeat (20) tick();
    chk("stall_saturate", 32'(STALL_CYCLES), 32'd15);
    CNT_CLEAR = 1;
    tick();
    chk("clear_wins", 32'(STALL_CYCLES), 32'd0);
    CNT_CLEAR = 0;
    tick();
    chk("count_after_clear", 32'(STALL_CYCLES), 32'd1);
    idle();

    // Asynchronous reset in the middle of a DMEM stall
    DMEM_BUSYWAIT = 1;
    tick();
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'(O_BOOT));
    chk("async_rst_state", 32'(CTRL_STATE), 32'd0);
    chk("async_rst_timeout", 32'(MEM_TIMEOUT), 32'd0);
    chk("async_rst_stall", 32'(STALL_CYCLES), 32'd0);
    tick();
    RESET = 1'b1;
    #4 chk("reboot_edge0", 32'(outs()), 32'(O_BOOT));
    tick();
    #4 chk("reboot_edge1", 32'(outs()), 32'(O_BOOT));
    tick();
    #4 chk("reboot_done_dstall", 32'(outs()), 32'(O_DST));
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
